// File: rtl/render_sched_pkg.sv
// Shared constants and types for the render update scheduler.
package render_sched_pkg;

  localparam logic [7:0]  SYNC_BYTE     = 8'hA5;
  localparam int unsigned PAYLOAD_BYTES = 4;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned POS_W         = 32;
  localparam int unsigned IDX_W         = $clog2(PAYLOAD_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    PAY,
    CHK
  } rx_state_t;

endpackage

// File: rtl/render_pos_fifo.sv
// Synchronous position FIFO; a pop in the same cycle frees a slot for a push when full.
module render_pos_fifo
  import render_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         push,
  input  logic [POS_W-1:0]             push_data,
  input  logic                         pop,
  output logic [POS_W-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [POS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign pop_ok_c  = pop && !empty;
  assign push_ok_c = push && (!full || pop_ok_c);
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop_ok_c)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      if (push_ok_c && !pop_ok_c)      count <= CNT_W'(count + 1'b1);
      else if (!push_ok_c && pop_ok_c) count <= CNT_W'(count - 1'b1);
    end
  end

endmodule

// File: rtl/render_update_scheduler.sv
// Frames UART bytes into checked 32-bit positions and releases one per vertical blank.
// Optional inter-byte timeout enabled by defining RENDER_SCHED_TIMEOUT_EN.
module render_update_scheduler
  import render_sched_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] i_rx_byte,
  input  logic              i_rx_valid,
  input  logic              n_vsync,
  output logic [POS_W-1:0]  o_render_pos,
  output logic              o_update,
  output logic              o_queue_full,
  output logic              o_drop,
  output logic              o_frame_err
);

  rx_state_t          state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [POS_W-1:0]   asm_q, asm_d;
  logic [BYTE_W-1:0]  chk_q, chk_d;
  logic               push_c;
  logic               err_c;
  logic               timeout_c;
  logic               vs_q;
  logic               pop_c;
  logic               fifo_full;
  logic               fifo_empty;
  logic [POS_W-1:0]   fifo_data;
  logic [$clog2(QUEUE_DEPTH):0] unused_count;

`ifdef RENDER_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  assign timeout_c = (state_q != IDLE) && !i_rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter while a packet is open; saturates at the limit
  always_ff @(posedge i_clk) begin
    if (i_rst || state_q == IDLE || i_rx_valid) tmo_q <= '0;
    else if (tmo_q != TMO_W'(TIMEOUT_CYCLES))   tmo_q <= TMO_W'(tmo_q + 1'b1);
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_c      = 1'b0;
`endif

  assign pop_c = vs_q && !n_vsync && !fifo_empty;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    chk_d   = chk_q;
    push_c  = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      IDLE: if (i_rx_valid && i_rx_byte == SYNC_BYTE) begin
        state_d = PAY;
        idx_d   = '0;
        chk_d   = '0;
      end
      PAY: if (i_rx_valid) begin
        asm_d = {asm_q[POS_W-BYTE_W-1:0], i_rx_byte};
        chk_d = chk_q ^ i_rx_byte;
        idx_d = IDX_W'(idx_q + 1'b1);
        if (idx_q == IDX_W'(PAYLOAD_BYTES - 1)) state_d = CHK;
      end
      CHK: if (i_rx_valid) begin
        state_d = IDLE;
        if (i_rx_byte == chk_q) push_c = 1'b1;
        else                    err_c  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (timeout_c) begin
      state_d = IDLE;
      err_c   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      asm_q        <= '0;
      chk_q        <= '0;
      vs_q         <= 1'b1;
      o_render_pos <= '0;
      o_update     <= 1'b0;
      o_drop       <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      chk_q        <= chk_d;
      vs_q         <= n_vsync;
      if (pop_c) o_render_pos <= fifo_data;
      o_update     <= pop_c;
      o_drop       <= push_c && fifo_full && !pop_c;
      o_frame_err  <= err_c;
    end
  end

  assign o_queue_full = fifo_full;

  render_pos_fifo #(
    .DEPTH(QUEUE_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .push     (push_c),
    .push_data(asm_q),
    .pop      (pop_c),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (unused_count)
  );

endmodule

// File: tb/tb_render_update_scheduler.sv
// Bench for render_update_scheduler: directed scenarios plus random traffic against a packet/queue model.
module tb_render_update_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 100;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_rx_byte = '0;
  logic        i_rx_valid = 1'b0;
  logic        n_vsync = 1'b1;
  logic [31:0] o_render_pos;
  logic        o_update, o_queue_full, o_drop, o_frame_err;

  always #5 i_clk = ~i_clk;

  render_update_scheduler #(
    .QUEUE_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx_byte   (i_rx_byte),
    .i_rx_valid  (i_rx_valid),
    .n_vsync     (n_vsync),
    .o_render_pos(o_render_pos),
    .o_update    (o_update),
    .o_queue_full(o_queue_full),
    .o_drop      (o_drop),
    .o_frame_err (o_frame_err)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] m_q [$];
  logic [7:0]  m_pkt [$];
  logic        m_vs  = 1'b1;
  logic [31:0] m_pos = '0;
  int          m_idle = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model by the packet/queue rules, compare outputs
  task automatic step(input logic rst, input logic vld, input logic [7:0] b, input logic nv);
    logic e_upd, e_drop, e_err, pop, good;
    logic [31:0] w;
    logic [7:0]  x;
    i_rst = rst; i_rx_valid = vld; i_rx_byte = b; n_vsync = nv;
    @(posedge i_clk);
    e_upd = 0; e_drop = 0; e_err = 0; good = 0; w = '0;
    if (rst) begin
      m_q.delete(); m_pkt.delete(); m_vs = 1'b1; m_pos = '0; m_idle = 0;
    end else begin
      pop = m_vs && !nv && (m_q.size() > 0);
      if (vld) begin
        m_idle = 0;
        if (m_pkt.size() != 0 || b == 8'hA5) m_pkt.push_back(b);
        if (m_pkt.size() == 6) begin
          w = {m_pkt[1], m_pkt[2], m_pkt[3], m_pkt[4]};
          x = m_pkt[1] ^ m_pkt[2] ^ m_pkt[3] ^ m_pkt[4];
          if (x == m_pkt[5]) good = 1; else e_err = 1;
          m_pkt.delete();
        end
      end
`ifdef RENDER_SCHED_TIMEOUT_EN
      else if (m_pkt.size() != 0) begin
        m_idle++;
        if (m_idle == int'(TMO)) begin
          m_pkt.delete(); m_idle = 0; e_err = 1;
        end
      end
`endif
      if (pop) begin m_pos = m_q.pop_front(); e_upd = 1; end
      if (good) begin
        if (m_q.size() < int'(DEPTH)) m_q.push_back(w);
        else e_drop = 1;
      end
      m_vs = nv;
    end
    #1;
    check_eq("render_pos", o_render_pos, m_pos);
    check_eq("update", 32'(o_update), 32'(e_upd));
    check_eq("drop", 32'(o_drop), 32'(e_drop));
    check_eq("frame_err", 32'(o_frame_err), 32'(e_err));
    check_eq("queue_full", 32'(o_queue_full), 32'(m_q.size() == int'(DEPTH)));
  endtask

  task automatic send_pkt(input logic [31:0] w, input logic bad, input logic nv_last);
    logic [7:0] c;
    c = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    if (bad) c = c ^ 8'h01;
    step(0, 1, 8'hA5, 1);
    step(0, 1, w[31:24], 1);
    step(0, 1, w[23:16], 1);
    step(0, 1, w[15:8], 1);
    step(0, 1, w[7:0], 1);
    step(0, 1, c, nv_last);
  endtask

  task automatic blank();
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
  endtask

  logic [7:0] stream [$];
  logic       nv_r;

  initial begin
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 0);
    check_eq("rst_pos", o_render_pos, 32'h0);
    check_eq("rst_full", 32'(o_queue_full), 32'h0);
    step(0, 0, 8'h00, 0);

    // Good packet, then one blank
    step(0, 0, 8'h00, 1);
    send_pkt(32'h12345678, 0, 1);
    step(0, 0, 8'h00, 0);
    check_eq("t1_pos", o_render_pos, 32'h12345678);
    check_eq("t1_upd", 32'(o_update), 32'h1);
    step(0, 0, 8'h00, 1);

    // Bad checksum, then a blank with nothing queued
    send_pkt(32'h12345678, 1, 1);
    blank();

    // Overfill, then drain in order
    for (int i = 1; i <= 5; i++) send_pkt(32'(i), 0, 1);
    for (int i = 0; i < 4; i++) blank();
    check_eq("t3_last", o_render_pos, 32'h4);

    // Fifth push coincides with a blank-start pop
    for (int i = 1; i <= 4; i++) send_pkt(32'(i), 0, 1);
    send_pkt(32'h5, 0, 0);
    check_eq("t4_pos", o_render_pos, 32'h1);
    check_eq("t4_full", 32'(o_queue_full), 32'h1);
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) blank();
    check_eq("t4_last", o_render_pos, 32'h5);

    // Long blank pops once; reset mid-packet
    for (int i = 0; i < 3; i++) send_pkt(32'hA0 + 32'(i), 0, 1);
    for (int i = 0; i < 1000; i++) step(0, 0, 8'h00, 0);
    check_eq("t5_pos", o_render_pos, 32'hA0);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'hA5, 1);
    step(0, 1, 8'hDE, 1);
    step(0, 1, 8'hAD, 1);
    step(1, 1, 8'hBE, 1);
    send_pkt(32'hCAFEF00D, 0, 1);
    blank();
    check_eq("t5_clean", o_render_pos, 32'hCAFEF00D);

`ifdef RENDER_SCHED_TIMEOUT_EN
    step(0, 1, 8'hA5, 1);
    step(0, 1, 8'h12, 1);
    for (int i = 0; i < int'(TMO); i++) step(0, 0, 8'h00, 1);
    check_eq("t6_err", 32'(o_frame_err), 32'h1);
    send_pkt(32'h0BADBEEF, 0, 1);
    blank();
    check_eq("t6_pos", o_render_pos, 32'h0BADBEEF);
`endif

    // Random packets, corruption, junk, vsync activity and occasional reset
    nv_r = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      logic        vld;
      logic [7:0]  b;
      logic [31:0] w;
      logic [7:0]  c;
      if (stream.size() == 0) begin
        if ($urandom_range(0, 7) == 0) stream.push_back(8'($urandom));
        else begin
          w = $urandom;
          c = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
          if ($urandom_range(0, 5) == 0) c = c ^ 8'($urandom_range(1, 255));
          stream.push_back(8'hA5);
          stream.push_back(w[31:24]); stream.push_back(w[23:16]);
          stream.push_back(w[15:8]);  stream.push_back(w[7:0]);
          stream.push_back(c);
        end
      end
      vld = ($urandom_range(0, 2) != 0);
      b = vld ? stream.pop_front() : 8'($urandom);
      if ($urandom_range(0, 15) == 0) nv_r = ~nv_r;
      if ($urandom_range(0, 799) == 0) begin
        step(1, vld, b, nv_r);
        stream.delete();
      end else begin
        step(0, vld, b, nv_r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/render_update_scheduler.md
# render_update_scheduler

Receives the UART byte stream, assembles and validates 32-bit render-position packets, and queues them. Releases exactly one queued position per vertical blank, so the renderer only sees a new position between frames. Sits between the UART receiver and the render core. Replaces direct capture of a raw UART word with framed, checked, rate-limited updates.

## Interface

**Parameters**
- `QUEUE_DEPTH`, 4: number of queued position words; power of two, 2..16.
- `TIMEOUT_CYCLES`, 1_000_000: inter-byte timeout in `i_clk` cycles. Used only with the timeout feature (see Configuration).

**Ports**
- `i_clk`, input, 1: the single clock; all logic is on its rising edge.
- `i_rst`, input, 1: reset, synchronous and active-high.
- `i_rx_byte`, input, 8: received UART byte.
- `i_rx_valid`, input, 1: one-cycle strobe; `i_rx_byte` is valid this cycle.
- `n_vsync`, input, 1: active-low vsync, already in the `i_clk` domain.
- `o_render_pos`, output, 32: currently committed render position.
- `o_update`, output, 1: one-cycle pulse when `o_render_pos` changes.
- `o_queue_full`, output, 1: queue holds `QUEUE_DEPTH` words.
- `o_drop`, output, 1: one-cycle pulse when a valid packet is discarded because the queue is full.
- `o_frame_err`, output, 1: one-cycle pulse on a checksum mismatch or timeout abort.

## Operation

**Packet format:** sync byte `0xA5`, then payload bytes P3 P2 P1 P0 (MSB first), then checksum C = P3^P2^P1^P0.

**Receive FSM states:** `IDLE`, `PAY`, `CHK`.
- `IDLE`: on `i_rx_valid` with byte `0xA5` → `PAY`, byte index = 0. Any other byte is ignored.
- `PAY`: each valid byte shifts into the 32-bit assembly register and XORs into the running checksum. After the 4th byte → `CHK`. A `0xA5` inside the payload is data, not a resync.
- `CHK`: on a valid byte → `IDLE`.
  - Byte == checksum: push the assembled word to the queue, or pulse `o_drop` if the queue is full.
  - Byte != checksum: pulse `o_frame_err`; nothing is pushed.

**Vsync scheduling:**
- Register `n_vsync` as `vs_q`. A blank start is `vs_q==1 && n_vsync==0`.
- On blank start with the queue non-empty: pop one word into `o_render_pos` and pulse `o_update`.
- With the queue empty, `o_render_pos` holds its value and `o_update` stays 0.
- At most one pop per blank, whatever the blank length.

**Simultaneous push and pop:**
- Both happen in the same cycle and the count is unchanged.
- If the queue is full, the pop frees the slot first: the push is accepted and `o_drop` is not pulsed.

**Reset:** `i_rst` in any state, including mid-packet, clears the following:
- FSM → `IDLE`; byte index, checksum and queue pointers/count cleared.
- `vs_q` set to 1, so reset during low `n_vsync` does not produce a blank start.

## Timing

- **Reset values:** `o_render_pos`=0, `o_update`=0, `o_queue_full`=0, `o_drop`=0, `o_frame_err`=0.
- **Checksum byte** accepted in cycle M:
  - Queue count, `o_queue_full`, `o_drop` and `o_frame_err` update in cycle M+1.
- **Blank start** detected in cycle N (sampled low, previous high):
  - `o_render_pos` and `o_update` are valid in cycle N+1.
  - A word pushed at M+1 can be popped by a blank start detected at M+1, giving output at M+2.
- **All outputs are registered.** No combinational path from inputs to outputs.
- **Arithmetic:** queue count is $clog2(QUEUE_DEPTH)+1 bits; pointers wrap modulo `QUEUE_DEPTH`; the timeout counter saturates.

## Configuration

Macro: `RENDER_SCHED_TIMEOUT_EN`.
- **Defined:**
  - In `PAY` or `CHK`, a counter reloads on each `i_rx_valid`.
  - If `TIMEOUT_CYCLES` cycles pass with no byte, the FSM returns to `IDLE`, discards the partial packet and pulses `o_frame_err`.
- **Undefined:** no counter is built; a partial packet waits indefinitely.

## Structure

- **Package `render_sched_pkg`:**
  - `SYNC_BYTE` = 8'hA5.
  - `PAYLOAD_BYTES` = 4.
  - Enum typedef `rx_state_t` {`IDLE`, `PAY`, `CHK`}.
- **Sub-module `render_pos_fifo`:** synchronous 32-bit FIFO with ports push, pop, full, empty and count.
  - Implements the pop-before-push rule when full.
  - The top level holds the FSM, vsync edge detect and output registers.

## Test plan

1. Reset, send A5 12 34 56 78 08, then pull `n_vsync` low → `o_render_pos`=0x12345678 with a one-cycle `o_update`, exactly one cycle after the edge is sampled.
2. Send A5 12 34 56 78 09 → `o_frame_err` pulses, queue count stays 0, and the next blank gives no `o_update`.
3. Send 5 valid packets (words 1..5) with no vsync, `QUEUE_DEPTH`=4 → `o_queue_full`=1 after the 4th and `o_drop` pulses on the 5th. Four subsequent blanks output 1, 2, 3, 4 in order.
4. Fill the queue, then align the 5th checksum byte's push cycle with a blank-start pop → the pop outputs word 1, word 5 is accepted, no `o_drop`, and the count stays 4.
5. Hold `n_vsync` low for 1000 cycles with 3 words queued → only one pop; assert `i_rst` during a packet at byte P1 → then a clean packet is received correctly.
6. With `RENDER_SCHED_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=100, send A5 12 and stall 100 cycles → `o_frame_err` pulses and the FSM is in `IDLE`. A following full packet is accepted.
